video_cfg_sequencer: RTL and testbench

Pushbutton-driven Avalon-MM configuration master for the video daisy chain, in the `sys_clk` domain. It sits directly upstream of the video core register slaves: the bar core and the rgb2gray core. It synchronizes and debounces a raw active-low key and samples two bypass switches. On each debounced press, and once automatically after reset, it issues one Avalon write to each core's control register (bar first, then rgb2gray), honoring waitrequest.

---
 rtl/video_cfg_sequencer.sv | 163 ++++++++++++++++
 tb/tb_video_cfg_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_cfg_sequencer.sv
// Pushbutton-driven Avalon-MM configuration master: debounces a key and writes the
// bypass bits of the bar and rgb2gray cores' control registers, once at startup and per press.
module video_cfg_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_n,
    input  logic        bar_core_bypass,
    input  logic        rgb2gray_core_bypass,
    input  logic        avs_video_bar_core_waitrequest,
    input  logic        avs_video_rgb2gray_core_waitrequest,
    output logic        avs_video_bar_core_address,
    output logic        avs_video_bar_core_write,
    output logic [31:0] avs_video_bar_core_writedata,
    output logic        avs_video_rgb2gray_core_address,
    output logic        avs_video_rgb2gray_core_write,
    output logic [31:0] avs_video_rgb2gray_core_writedata,
    output logic        busy,
    output logic [7:0]  seq_count
);

    localparam logic [23:0] DbLast = 24'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWrBar,
        StWrGray,
        StDone
    } state_e;

    logic        key_s1_q, key_s2_q;
    logic        bar_s1_q, bar_s2_q;
    logic        gray_s1_q, gray_s2_q;

    logic [23:0] db_cnt_q, db_cnt_d;
    logic        key_db_q, key_db_d;
    logic        key_db_prev_q;
    logic        press;

    logic [1:0]  start_cnt_q;
    logic        init_pend_q;
    logic        init_ready;

    state_e      state_q, state_d;
    logic        launch;
    logic        lat_bar_q, lat_gray_q;
    logic [7:0]  seq_count_q;

    // Key flops idle high so reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            bar_s1_q  <= 1'b0;
            bar_s2_q  <= 1'b0;
            gray_s1_q <= 1'b0;
            gray_s2_q <= 1'b0;
        end else begin
            key_s1_q  <= key_n;
            key_s2_q  <= key_s1_q;
            bar_s1_q  <= bar_core_bypass;
            bar_s2_q  <= bar_s1_q;
            gray_s1_q <= rgb2gray_core_bypass;
            gray_s2_q <= gray_s1_q;
        end
    end

    always_comb begin
        db_cnt_d = '0;
        key_db_d = key_db_q;
        if (key_s2_q != key_db_q) begin
            if (db_cnt_q == DbLast) begin
                key_db_d = key_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 24'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            db_cnt_q      <= '0;
            key_db_q      <= 1'b1;
            key_db_prev_q <= 1'b1;
        end else begin
            db_cnt_q      <= db_cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
        end
    end

    assign press = key_db_prev_q & ~key_db_q;

    // Startup launch waits until the switch synchronizers hold real samples.
    assign init_ready = init_pend_q && (start_cnt_q == 2'd3);

    always_comb begin
        state_d                       = state_q;
        launch                        = 1'b0;
        busy                          = 1'b1;
        avs_video_bar_core_write      = 1'b0;
        avs_video_rgb2gray_core_write = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (press || init_ready) begin
                    launch  = 1'b1;
                    state_d = StWrBar;
                end
            end
            StWrBar: begin
                avs_video_bar_core_write = 1'b1;
                if (!avs_video_bar_core_waitrequest) begin
                    state_d = StWrGray;
                end
            end
            StWrGray: begin
                avs_video_rgb2gray_core_write = 1'b1;
                if (!avs_video_rgb2gray_core_waitrequest) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            start_cnt_q <= 2'd0;
            init_pend_q <= 1'b1;
            lat_bar_q   <= 1'b0;
            lat_gray_q  <= 1'b0;
            seq_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (start_cnt_q != 2'd3) begin
                start_cnt_q <= start_cnt_q + 2'd1;
            end
            if (launch) begin
                lat_bar_q   <= bar_s2_q;
                lat_gray_q  <= gray_s2_q;
                init_pend_q <= 1'b0;
            end
            if (state_q == StDone) begin
                seq_count_q <= seq_count_q + 8'd1;
            end
        end
    end

    assign avs_video_bar_core_address        = 1'b0;
    assign avs_video_rgb2gray_core_address   = 1'b0;
    assign avs_video_bar_core_writedata      = {31'b0, lat_bar_q};
    assign avs_video_rgb2gray_core_writedata = {31'b0, lat_gray_q};
    assign seq_count                         = seq_count_q;

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Bench for video_cfg_sequencer: directed stimulus pushes expected Avalon writes into a queue;
// a negedge monitor pops and compares each completed transfer.
`timescale 1ns/1ps
module tb_video_cfg_sequencer;

    localparam int unsigned Db = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_n = 1'b1;
    logic        bar_sw = 1'b0;
    logic        gray_sw = 1'b0;
    logic        bar_wait = 1'b0;
    logic        gray_wait = 1'b0;
    logic        bar_addr, bar_write, gray_addr, gray_write, busy;
    logic [31:0] bar_data, gray_data;
    logic [7:0]  seq_count;

    typedef struct {
        logic        gray;
        logic [31:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    video_cfg_sequencer #(.DEBOUNCE_CYCLES(Db)) dut (
        .sys_clk                             (sys_clk),
        .sys_rst_n                           (sys_rst_n),
        .key_n                               (key_n),
        .bar_core_bypass                     (bar_sw),
        .rgb2gray_core_bypass                (gray_sw),
        .avs_video_bar_core_waitrequest      (bar_wait),
        .avs_video_rgb2gray_core_waitrequest (gray_wait),
        .avs_video_bar_core_address          (bar_addr),
        .avs_video_bar_core_write            (bar_write),
        .avs_video_bar_core_writedata        (bar_data),
        .avs_video_rgb2gray_core_address     (gray_addr),
        .avs_video_rgb2gray_core_write       (gray_write),
        .avs_video_rgb2gray_core_writedata   (gray_data),
        .busy                                (busy),
        .seq_count                           (seq_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_seq(input logic b, input logic g);
        exp_q.push_back('{gray: 1'b0, data: {31'b0, b}});
        exp_q.push_back('{gray: 1'b1, data: {31'b0, g}});
    endtask

    task automatic pop_cmp(input logic gray, input logic [31:0] data, input logic addr);
        xfer_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL xfer: unexpected write port=%0d data=0x%0h, none required", gray, data);
        end else begin
            e = exp_q.pop_front();
            if (e.gray === gray && e.data === data && addr === 1'b0) n_pass++;
            else $display("FAIL xfer: got port=%0d data=0x%0h addr=%0d, required port=%0d data=0x%0h addr=0",
                          gray, data, addr, e.gray, e.data);
        end
    endtask

    task automatic wait_write(input logic gray, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (gray ? gray_write : bar_write) found = 1'b1;
        end
        n_checks++;
        if (found) n_pass++;
        else $display("FAIL wait_write: no write on port %0d within %0d cycles, required one", gray, budget);
    endtask

    task automatic press_key(input int low, input int high);
        key_n = 1'b0;
        repeat (low) tick();
        key_n = 1'b1;
        repeat (high) tick();
    endtask

    // Monitor: a transfer completes when write is high and waitrequest low.
    always @(negedge sys_clk) begin
        if (sys_rst_n && (bar_write || gray_write)) begin
            check("one_hot_write", {31'b0, bar_write & gray_write}, 32'd0);
            if (bar_write && !bar_wait) pop_cmp(1'b0, bar_data, bar_addr);
            if (gray_write && !gray_wait) pop_cmp(1'b1, gray_data, gray_addr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbar, ngray, nwr;
        logic data_ok;

        // Reset init
        bar_sw  = 1'b1;
        gray_sw = 1'b0;
        repeat (3) tick();
        check("rst_writes", {30'b0, bar_write, gray_write}, 32'd0);
        check("rst_data", bar_data | gray_data, 32'd0);
        check("rst_addr", {30'b0, bar_addr, gray_addr}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_count", {24'b0, seq_count}, 32'd0);
        sys_rst_n = 1'b1;
        expect_seq(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("init_not_early", {31'b0, bar_write}, 32'd0);
        end
        tick();
        check("init_bar_c4", {31'b0, bar_write}, 32'd1);
        check("init_bar_data", bar_data, 32'd1);
        check("init_busy", {31'b0, busy}, 32'd1);
        tick();
        check("init_gray_c5", {31'b0, gray_write}, 32'd1);
        check("init_gray_data", gray_data, 32'd0);
        tick();
        check("init_done_nowrite", {30'b0, bar_write, gray_write}, 32'd0);
        check("init_count_c6", {24'b0, seq_count}, 32'd0);
        tick();
        check("init_count_c7", {24'b0, seq_count}, 32'd1);
        check("init_idle", {31'b0, busy}, 32'd0);

        // Press with bar waitrequest stalling three cycles
        bar_sw  = 1'b0;
        gray_sw = 1'b1;
        repeat (3) tick();
        bar_wait = 1'b1;
        expect_seq(1'b0, 1'b1);
        key_n = 1'b0;
        nbar = 0;
        ngray = 0;
        data_ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (c == 9) key_n = 1'b1;
            if (bar_write) begin
                nbar++;
                if (bar_data !== 32'd0) data_ok = 1'b0;
                if (nbar == 4) bar_wait = 1'b0;
            end
            if (gray_write) ngray++;
        end
        bar_wait = 1'b0;
        check("stall_bar_cycles", nbar, 32'd4);
        check("stall_bar_data", {31'b0, data_ok}, 32'd1);
        check("stall_gray_cycles", ngray, 32'd1);
        check("stall_count", {24'b0, seq_count}, 32'd2);

        // Glitch rejection
        key_n = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        nwr = 0;
        repeat (20) begin
            tick();
            if (bar_write || gray_write || busy) nwr++;
        end
        check("glitch_activity", nwr, 32'd0);
        check("glitch_count", {24'b0, seq_count}, 32'd2);

        // Busy drop: second press during a long rgb2gray stall
        gray_wait = 1'b1;
        expect_seq(1'b0, 1'b1);
        press_key(8, 0);
        wait_write(1'b1, 20);
        press_key(8, 10);
        check("drop_busy", {31'b0, busy}, 32'd1);
        repeat (30) tick();
        gray_wait = 1'b0;
        repeat (20) tick();
        check("drop_count", {24'b0, seq_count}, 32'd3);
        check("drop_idle", {31'b0, busy}, 32'd0);

        // Switch latch while bar is stalled
        bar_wait = 1'b1;
        expect_seq(1'b0, 1'b1);
        key_n = 1'b0;
        wait_write(1'b0, 20);
        key_n = 1'b1;
        data_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bar_sw = ~bar_sw;
            tick();
            if (bar_data !== 32'd0 || !bar_write) data_ok = 1'b0;
        end
        check("latch_data_stable", {31'b0, data_ok}, 32'd1);
        bar_sw   = 1'b1;
        bar_wait = 1'b0;
        repeat (15) tick();
        check("latch_count", {24'b0, seq_count}, 32'd4);

        // Wrap: 252 more presses take the count from 4 round to 0
        for (int i = 0; i < 252; i++) begin
            expect_seq(1'b1, 1'b1);
            press_key(8, 10);
            if (i == 250) check("wrap_255", {24'b0, seq_count}, 32'd255);
        end
        check("wrap_zero", {24'b0, seq_count}, 32'd0);

        // Async reset during WR_GRAY
        gray_wait = 1'b1;
        expect_seq(1'b1, 1'b1);
        key_n = 1'b0;
        wait_write(1'b1, 20);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_gray_drop", {31'b0, gray_write}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_pending", exp_q.size(), 32'd1);
        exp_q.delete();
        key_n     = 1'b1;
        gray_wait = 1'b0;
        bar_sw    = 1'b0;
        gray_sw   = 1'b1;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        expect_seq(1'b0, 1'b1);
        repeat (3) tick();
        check("replay_not_early", {31'b0, bar_write}, 32'd0);
        tick();
        check("replay_bar_c4", {31'b0, bar_write}, 32'd1);
        repeat (6) tick();
        check("replay_count", {24'b0, seq_count}, 32'd1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
